morse_symbol_framer: RTL and testbench
======================================

// Module: morse_symbol_framer
// PURPOSE
//  Parametrised key-timing front end for the Morse decoder. Measures key_in press length in clk_in cycles and
//  classifies each press as DOT or DASH with programmable thresholds. Packs symbols into a letter frame and
//  hands complete letters downstream on a valid/ready interface. Sits between board switches and the letter lookup.
// PARAMETERS
//  MAX_SYMBOLS  5                          max symbols per letter frame
//  CNT_W        8                          press/idle counter width; counters saturate at 2**CNT_W-1
//  DASH_TH      6                          press count > DASH_TH -> DASH, else DOT
//  MIN_PRESS    1                          press count < MIN_PRESS -> glitch, dropped
//  GAP_CYCLES   32                         idle cycles that close a letter (only with MORSE_AUTOGAP_EN)
//  LEN_W        $clog2(MAX_SYMBOLS+1)      letter length width
// PORTS
//  clk_in        in   1            system clock
//  rst           in   1            asynchronous reset, active-high
//  key_in        in   1            Morse key switch, asynchronous
//  sep_in        in   1            letter-separator switch, asynchronous
//  sym_valid     out  1            one-cycle pulse: sym_type is valid
//  sym_type      out  2            GAP/DOT/DASH/STOP
//  letter_valid  out  1            letter frame available
//  letter_ready  in   1            downstream accepts the frame
//  letter_bits   out  MAX_SYMBOLS  symbol i at bit i: 1=DASH, 0=DOT; unused bits 0
//  letter_len    out  LEN_W        symbols in the frame, 1..MAX_SYMBOLS
//  letter_ovf    out  1            frame dropped one or more symbols
// BEHAVIOUR
//  Reset: all outputs 0 except sym_type=STOP. Accumulator and counters clear; pending flag clears; FSM enters LOCKOUT.
//  key_in and sep_in each pass through a 2-flop synchroniser; edge detection runs on the synchronised values.
//  Key FSM:
//    LOCKOUT -> IDLE when key low. A key held across reset produces no symbol.
//    IDLE -> PRESS on key rise. The press counter loads 1.
//    PRESS: counter increments each cycle the key is high, saturating.
//      On key fall: count>DASH_TH -> DASH; count>=MIN_PRESS -> DOT; otherwise dropped. Then -> IDLE.
//  Symbol commit: sym_valid pulses with the type 3 cycles after key_in falls (2 sync + 1 reg).
//    The symbol is written to accumulator bit acc_len and acc_len increments.
//    If acc_len==MAX_SYMBOLS: the symbol is dropped and acc_ovf is set. sym_valid still pulses.
//  Separator (sep rising edge):
//    acc_len==0: sym_valid pulses with sym_type=GAP. No frame is produced.
//    acc_len>0 and output slot empty: bits/len/ovf move to the output regs.
//      letter_valid=1 three cycles after sep_in rises. The accumulator clears in the same cycle.
//    Output slot full: a 1-bit pending flag is set. The frame closes on the cycle after the handshake completes.
//      Further separators while pending are absorbed.
//  Same-cycle symbol commit and separator: the symbol is included in the closing frame.
//  Handshake: letter_valid and the payload are held stable until letter_valid&&letter_ready.
//    letter_valid drops the next cycle unless a pending frame reloads it, giving back-to-back valid.
//  Symbols keep accumulating while the output slot is full. No input is stalled.
// CONFIGURATION
//  MORSE_AUTOGAP_EN defined:
//    An idle counter runs while the FSM is IDLE and acc_len>0, and clears on key rise.
//    On reaching GAP_CYCLES it acts exactly as a separator event (one event per idle period).
//  Not defined: letters close only on sep_in. The idle counter is not built.
// STRUCTURE
//  Package morse_pkg: sym_type encodings GAP=2'b00, DOT=2'b01, DASH=2'b10, STOP=2'b11; key FSM state encodings.
//  Sub-module morse_sync_edge: 2-flop synchroniser plus rise/fall pulses.
//    Instantiated twice, for key_in and sep_in. All other logic is in this module.
// TESTING (DASH_TH=6, MIN_PRESS=1, MAX_SYMBOLS=5, ready=1 unless stated)
//  1. Press 3 cycles, press 10 cycles, sep -> sym DOT then DASH; letter_len=2, letter_bits=5'b00010, ovf=0 ("A").
//  2. Press 7 cycles -> DASH. Press exactly 6 cycles -> DOT. With MIN_PRESS=2, a 1-cycle press -> no sym_valid.
//  3. Six 3-cycle presses, sep -> letter_len=5, letter_bits=0, letter_ovf=1; six sym_valid pulses.
//  4. letter_ready=0: letter, then 2 dots + sep -> first frame held stable; after ready=1 for 1 cycle,
//     second frame valid next cycle with len=2.
//  5. Assert rst mid-press and hold key across release -> no sym_valid until key goes low and is pressed again.
//  6. MORSE_AUTOGAP_EN, GAP_CYCLES=32: one dash, idle 40 cycles -> single frame len=1, bits=1; sep with empty acc -> GAP pulse.

Source files
------------

// File: rtl/morse_pkg.sv
`default_nettype none
//============================================================================
// Package : morse_pkg
// Desc    : Symbol and key-FSM encodings shared by the Morse framer blocks.
// Rev     : 1.0  initial release
//============================================================================
package morse_pkg;

   typedef enum logic [1:0] {
      SYM_GAP  = 2'b00,
      SYM_DOT  = 2'b01,
      SYM_DASH = 2'b10,
      SYM_STOP = 2'b11
   } sym_t;

   typedef enum logic [1:0] {
      ST_LOCKOUT = 2'b00,
      ST_IDLE    = 2'b01,
      ST_PRESS   = 2'b10
   } key_state_t;

   // SYM_STOP is returned for presses too short to count as a symbol.
   function automatic sym_t classify_press(input int count, input int dash_th, input int min_press);
      sym_t result;
      if (count > dash_th)
         result = SYM_DASH;
      else if (count >= min_press)
         result = SYM_DOT;
      else
         result = SYM_STOP;
      return result;
   endfunction

endpackage : morse_pkg
`default_nettype wire

// File: rtl/morse_sync_edge.sv
`default_nettype none
//============================================================================
// Module  : morse_sync_edge
// Desc    : Two-flop synchroniser for a switch input with rise/fall pulses.
// Rev     : 1.0  initial release
//============================================================================
module morse_sync_edge #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk_in,
   input  logic rst,
   input  logic async_in,
   output logic level,
   output logic rise,
   output logic fall
);

   // sh[1] is the synchronised level, sh[2] its one-cycle-old copy.
   logic [2:0] sh;

   always_ff @(posedge clk_in or posedge rst) begin
      if (rst)
         sh <= {3{RST_VAL}};
      else
         sh <= {sh[1:0], async_in};
   end

   assign level = sh[1];
   assign rise  = sh[1] & ~sh[2];
   assign fall  = ~sh[1] & sh[2];

endmodule : morse_sync_edge
`default_nettype wire

// File: rtl/morse_symbol_framer.sv
`default_nettype none
//============================================================================
// Module  : morse_symbol_framer
// Desc    : Times key presses into DOT/DASH symbols and packs them into letter
//           frames on a valid/ready port. Define MORSE_AUTOGAP_EN to also close
//           a letter after GAP_CYCLES of key idle time.
// Rev     : 1.0  initial release
//============================================================================
module morse_symbol_framer #(
   parameter int MAX_SYMBOLS = 5,
   parameter int CNT_W       = 8,
   parameter int DASH_TH     = 6,
   parameter int MIN_PRESS   = 1,
   parameter int GAP_CYCLES  = 32,
   parameter int LEN_W       = $clog2(MAX_SYMBOLS + 1)
) (
   input  logic                   clk_in,
   input  logic                   rst,
   input  logic                   key_in,
   input  logic                   sep_in,
   output logic                   sym_valid,
   output logic [1:0]             sym_type,
   output logic                   letter_valid,
   input  logic                   letter_ready,
   output logic [MAX_SYMBOLS-1:0] letter_bits,
   output logic [LEN_W-1:0]       letter_len,
   output logic                   letter_ovf
);
   import morse_pkg::*;

   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [LEN_W-1:0] LEN_FULL = LEN_W'(MAX_SYMBOLS);

   logic key_level, key_rise, key_fall;
   logic sep_level, sep_rise, sep_fall;
   logic sep_unused;

   // Synchronisers reset high so a switch held across reset never looks like a new press.
   morse_sync_edge #(.RST_VAL(1'b1)) u_key_sync (
      .clk_in   (clk_in),
      .rst      (rst),
      .async_in (key_in),
      .level    (key_level),
      .rise     (key_rise),
      .fall     (key_fall)
   );

   morse_sync_edge #(.RST_VAL(1'b1)) u_sep_sync (
      .clk_in   (clk_in),
      .rst      (rst),
      .async_in (sep_in),
      .level    (sep_level),
      .rise     (sep_rise),
      .fall     (sep_fall)
   );

   assign sep_unused = sep_level ^ sep_fall;

   key_state_t             state;
   logic [CNT_W-1:0]       press_cnt;
   sym_t                   press_sym;
   logic                   sym_commit;

   logic [MAX_SYMBOLS-1:0] acc_bits, acc_bits_nx;
   logic [LEN_W-1:0]       acc_len, acc_len_nx;
   logic                   acc_ovf, acc_ovf_nx;
   logic                   pending;
   sym_t                   sym_code;

   logic                   gap_event;
   logic                   sep_event;
   logic                   slot_free;
   logic                   handshake;
   logic                   load_out;
   logic                   set_pending;
   logic                   gap_pulse;

   assign press_sym  = classify_press(int'(press_cnt), DASH_TH, MIN_PRESS);
   assign sym_commit = (state == ST_PRESS) && key_fall && (press_sym != SYM_STOP);

   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         state     <= ST_LOCKOUT;
         press_cnt <= '0;
      end else begin
         case (state)
            ST_LOCKOUT: begin
               if (!key_level)
                  state <= ST_IDLE;
            end
            ST_IDLE: begin
               if (key_rise) begin
                  state     <= ST_PRESS;
                  press_cnt <= {{(CNT_W-1){1'b0}}, 1'b1};
               end
            end
            ST_PRESS: begin
               if (key_fall)
                  state <= ST_IDLE;
               else if (key_level && (press_cnt != CNT_MAX))
                  press_cnt <= press_cnt + 1'b1;
            end
            default: state <= ST_LOCKOUT;
         endcase
      end
   end

   // Accumulator contents including any symbol committing this cycle.
   always_comb begin
      acc_bits_nx = acc_bits;
      acc_len_nx  = acc_len;
      acc_ovf_nx  = acc_ovf;
      if (sym_commit) begin
         if (acc_len == LEN_FULL) begin
            acc_ovf_nx = 1'b1;
         end else begin
            for (int i = 0; i < MAX_SYMBOLS; i++) begin
               if (acc_len == LEN_W'(i))
                  acc_bits_nx[i] = (press_sym == SYM_DASH);
            end
            acc_len_nx = acc_len + 1'b1;
         end
      end
   end

`ifdef MORSE_AUTOGAP_EN
   localparam logic [CNT_W-1:0] GAP_LIMIT = CNT_W'(GAP_CYCLES);

   logic [CNT_W-1:0] idle_cnt;
   logic             idle_run;

   assign idle_run = (state == ST_IDLE) && !key_rise && (acc_len != '0);

   // Holds at GAP_LIMIT so one idle period yields a single event.
   always_ff @(posedge clk_in or posedge rst) begin
      if (rst)
         idle_cnt <= '0;
      else if (!idle_run)
         idle_cnt <= '0;
      else if (idle_cnt != GAP_LIMIT)
         idle_cnt <= idle_cnt + 1'b1;
   end

   assign gap_event = idle_run && (idle_cnt == GAP_LIMIT - 1'b1);
`else
   localparam int unused_gap_cycles = GAP_CYCLES;
   assign gap_event = 1'b0;
`endif

   assign sep_event   = sep_rise || gap_event;
   assign handshake   = letter_valid && letter_ready;
   assign slot_free   = !letter_valid || letter_ready;
   assign load_out    = (sep_event && !pending && (acc_len_nx != '0) && slot_free) ||
                        (pending && handshake);
   assign set_pending = sep_event && !pending && (acc_len_nx != '0) && !slot_free;
   assign gap_pulse   = sep_event && !pending && (acc_len_nx == '0);

   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         sym_valid    <= 1'b0;
         sym_code     <= SYM_STOP;
         letter_valid <= 1'b0;
         letter_bits  <= '0;
         letter_len   <= '0;
         letter_ovf   <= 1'b0;
         acc_bits     <= '0;
         acc_len      <= '0;
         acc_ovf      <= 1'b0;
         pending      <= 1'b0;
      end else begin
         sym_valid <= sym_commit || gap_pulse;
         if (sym_commit)
            sym_code <= press_sym;
         else if (gap_pulse)
            sym_code <= SYM_GAP;

         if (load_out) begin
            letter_valid <= 1'b1;
            letter_bits  <= acc_bits_nx;
            letter_len   <= acc_len_nx;
            letter_ovf   <= acc_ovf_nx;
            acc_bits     <= '0;
            acc_len      <= '0;
            acc_ovf      <= 1'b0;
            pending      <= 1'b0;
         end else begin
            acc_bits <= acc_bits_nx;
            acc_len  <= acc_len_nx;
            acc_ovf  <= acc_ovf_nx;
            if (handshake)
               letter_valid <= 1'b0;
            if (set_pending)
               pending <= 1'b1;
         end
      end
   end

   assign sym_type = sym_code;

endmodule : morse_symbol_framer
`default_nettype wire

// File: tb/tb_morse_symbol_framer.sv
`default_nettype none
//============================================================================
// Module  : tb_morse_symbol_framer
// Desc    : Directed self-checking bench for morse_symbol_framer.
// Rev     : 1.0  initial release
//============================================================================
module tb_morse_symbol_framer;
   import morse_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       key = 1'b0;
   logic       sep = 1'b0;
   logic       ready = 1'b1;

   logic       sym_valid, letter_valid, letter_ovf;
   logic [1:0] sym_type;
   logic [4:0] letter_bits;
   logic [2:0] letter_len;

   logic       sym_valid2, letter_valid2, letter_ovf2;
   logic [1:0] sym_type2;
   logic [4:0] letter_bits2;
   logic [2:0] letter_len2;

   int nchecks = 0;
   int nfail   = 0;

   typedef struct packed {
      logic [4:0] bits;
      logic [2:0] len;
      logic       ovf;
   } letter_t;

   logic [1:0] sym_q[$];
   letter_t    let_q[$];
   int         dut2_pulses = 0;

   always #5 clk = ~clk;

   morse_symbol_framer dut (
      .clk_in       (clk),
      .rst          (rst),
      .key_in       (key),
      .sep_in       (sep),
      .sym_valid    (sym_valid),
      .sym_type     (sym_type),
      .letter_valid (letter_valid),
      .letter_ready (ready),
      .letter_bits  (letter_bits),
      .letter_len   (letter_len),
      .letter_ovf   (letter_ovf)
   );

   morse_symbol_framer #(.MIN_PRESS(2)) dut2 (
      .clk_in       (clk),
      .rst          (rst),
      .key_in       (key),
      .sep_in       (sep),
      .sym_valid    (sym_valid2),
      .sym_type     (sym_type2),
      .letter_valid (letter_valid2),
      .letter_ready (1'b1),
      .letter_bits  (letter_bits2),
      .letter_len   (letter_len2),
      .letter_ovf   (letter_ovf2)
   );

   always @(negedge clk) begin
      if (sym_valid)
         sym_q.push_back(sym_type);
      if (letter_valid && ready)
         let_q.push_back({letter_bits, letter_len, letter_ovf});
      if (sym_valid2)
         dut2_pulses++;
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic press(input int n);
      key = 1'b1;
      idle(n);
      key = 1'b0;
   endtask

   task automatic pulse_sep();
      sep = 1'b1;
      idle(2);
      sep = 1'b0;
   endtask

   task automatic clear_queues();
      sym_q.delete();
      let_q.delete();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle(3);
      @(negedge clk);
      nchecks++;
      if (sym_valid !== 1'b0) begin nfail++; $display("FAIL reset_sym_valid got=%b exp=0", sym_valid); end
      nchecks++;
      if (sym_type !== SYM_STOP) begin nfail++; $display("FAIL reset_sym_type got=%b exp=11", sym_type); end
      nchecks++;
      if (letter_valid !== 1'b0) begin nfail++; $display("FAIL reset_letter_valid got=%b exp=0", letter_valid); end
      nchecks++;
      if (letter_bits !== 5'b0 || letter_len !== 3'd0 || letter_ovf !== 1'b0) begin
         nfail++; $display("FAIL reset_payload got=%b/%0d/%b exp=00000/0/0", letter_bits, letter_len, letter_ovf);
      end
      tick();
      rst = 1'b0;
      idle(6);
   endtask

   task automatic test_letter_a();
      clear_queues();
      press(3);
      idle(4);
      press(10);
      repeat (3) @(negedge clk);
      nchecks++;
      if (sym_valid !== 1'b0) begin nfail++; $display("FAIL a_early_pulse got=%b exp=0", sym_valid); end
      @(negedge clk);
      nchecks++;
      if (sym_valid !== 1'b1 || sym_type !== SYM_DASH) begin
         nfail++; $display("FAIL a_latency got=%b/%b exp=1/10", sym_valid, sym_type);
      end
      idle(3);
      pulse_sep();
      idle(6);
      nchecks++;
      if (sym_q.size() != 2 || sym_q[0] !== SYM_DOT || sym_q[1] !== SYM_DASH) begin
         nfail++; $display("FAIL a_symbols got_count=%0d exp=2 (DOT,DASH)", sym_q.size());
      end
      nchecks++;
      if (let_q.size() != 1 || let_q[0] !== {5'b00010, 3'd2, 1'b0}) begin
         nfail++; $display("FAIL a_letter got_count=%0d exp=1 bits=00010 len=2 ovf=0", let_q.size());
      end
   endtask

   task automatic test_thresholds();
      int d2;
      clear_queues();
      press(7);
      idle(6);
      press(6);
      idle(6);
      d2 = dut2_pulses;
      press(1);
      idle(6);
      nchecks++;
      if (dut2_pulses != d2) begin
         nfail++; $display("FAIL glitch_drop got=%0d exp=%0d", dut2_pulses, d2);
      end
      nchecks++;
      if (sym_q.size() != 3 || sym_q[0] !== SYM_DASH || sym_q[1] !== SYM_DOT || sym_q[2] !== SYM_DOT) begin
         nfail++; $display("FAIL thresholds got_count=%0d exp=3 (DASH,DOT,DOT)", sym_q.size());
      end
      d2 = dut2_pulses;
      press(2);
      idle(6);
      nchecks++;
      if (dut2_pulses != d2 + 1) begin
         nfail++; $display("FAIL min_press_edge got=%0d exp=%0d", dut2_pulses, d2 + 1);
      end
      pulse_sep();
      idle(6);
      nchecks++;
      if (let_q.size() != 1 || let_q[0] !== {5'b00001, 3'd4, 1'b0}) begin
         nfail++; $display("FAIL thr_letter got_count=%0d exp=1 bits=00001 len=4 ovf=0", let_q.size());
      end
   endtask

   task automatic test_overflow();
      clear_queues();
      repeat (6) begin
         press(3);
         idle(5);
      end
      pulse_sep();
      idle(6);
      nchecks++;
      if (sym_q.size() != 6 || sym_q[5] !== SYM_DOT) begin
         nfail++; $display("FAIL ovf_pulses got=%0d exp=6", sym_q.size());
      end
      nchecks++;
      if (let_q.size() != 1 || let_q[0] !== {5'b00000, 3'd5, 1'b1}) begin
         nfail++; $display("FAIL ovf_letter got_count=%0d exp=1 bits=00000 len=5 ovf=1", let_q.size());
      end
      press(10);
      idle(5);
      pulse_sep();
      idle(6);
      nchecks++;
      if (let_q.size() != 2 || let_q[1] !== {5'b00001, 3'd1, 1'b0}) begin
         nfail++; $display("FAIL ovf_cleared got_count=%0d exp=2 second bits=00001 len=1 ovf=0", let_q.size());
      end
   endtask

   task automatic test_back_to_back();
      clear_queues();
      ready = 1'b0;
      press(10);
      idle(5);
      pulse_sep();
      idle(5);
      nchecks++;
      if (letter_valid !== 1'b1 || letter_len !== 3'd1 || letter_bits !== 5'b00001) begin
         nfail++; $display("FAIL b2b_first got=%b/%0d/%b exp=1/1/00001", letter_valid, letter_len, letter_bits);
      end
      press(3);
      idle(5);
      press(3);
      idle(5);
      pulse_sep();
      idle(6);
      nchecks++;
      if (letter_valid !== 1'b1 || letter_len !== 3'd1 || letter_bits !== 5'b00001 || letter_ovf !== 1'b0) begin
         nfail++; $display("FAIL b2b_hold got=%b/%0d/%b exp=1/1/00001", letter_valid, letter_len, letter_bits);
      end
      nchecks++;
      if (sym_q.size() != 3 || let_q.size() != 0) begin
         nfail++; $display("FAIL b2b_accum got_syms=%0d letters=%0d exp=3/0", sym_q.size(), let_q.size());
      end
      ready = 1'b1;
      tick();
      ready = 1'b0;
      @(negedge clk);
      nchecks++;
      if (letter_valid !== 1'b1 || letter_len !== 3'd2 || letter_bits !== 5'b00000) begin
         nfail++; $display("FAIL b2b_second got=%b/%0d/%b exp=1/2/00000", letter_valid, letter_len, letter_bits);
      end
      ready = 1'b1;
      idle(3);
      nchecks++;
      if (let_q.size() != 2 || let_q[0] !== {5'b00001, 3'd1, 1'b0} || let_q[1] !== {5'b00000, 3'd2, 1'b0}) begin
         nfail++; $display("FAIL b2b_order got_count=%0d exp=2", let_q.size());
      end
      nchecks++;
      if (letter_valid !== 1'b0) begin nfail++; $display("FAIL b2b_drain got=%b exp=0", letter_valid); end
   endtask

   task automatic test_reset_mid_press();
      clear_queues();
      key = 1'b1;
      idle(5);
      rst = 1'b1;
      idle(2);
      rst = 1'b0;
      idle(10);
      key = 1'b0;
      idle(8);
      nchecks++;
      if (sym_q.size() != 0) begin nfail++; $display("FAIL lockout got=%0d pulses exp=0", sym_q.size()); end
      press(3);
      idle(6);
      nchecks++;
      if (sym_q.size() != 1 || sym_q[0] !== SYM_DOT) begin
         nfail++; $display("FAIL post_lockout got_count=%0d exp=1 DOT", sym_q.size());
      end
      pulse_sep();
      idle(6);
   endtask

   task automatic test_gap();
      clear_queues();
      pulse_sep();
      idle(6);
      nchecks++;
      if (sym_q.size() != 1 || sym_q[0] !== SYM_GAP) begin
         nfail++; $display("FAIL gap_pulse got_count=%0d exp=1 GAP", sym_q.size());
      end
      nchecks++;
      if (let_q.size() != 0) begin nfail++; $display("FAIL gap_no_letter got=%0d exp=0", let_q.size()); end
   endtask

`ifdef MORSE_AUTOGAP_EN
   task automatic test_autogap();
      clear_queues();
      press(10);
      idle(40);
      nchecks++;
      if (let_q.size() != 1 || let_q[0] !== {5'b00001, 3'd1, 1'b0}) begin
         nfail++; $display("FAIL autogap_letter got_count=%0d exp=1 bits=00001 len=1", let_q.size());
      end
      idle(40);
      nchecks++;
      if (let_q.size() != 1 || sym_q.size() != 1) begin
         nfail++; $display("FAIL autogap_single got_letters=%0d syms=%0d exp=1/1", let_q.size(), sym_q.size());
      end
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_letter_a();
      test_thresholds();
      test_overflow();
      test_back_to_back();
      test_reset_mid_press();
      test_gap();
`ifdef MORSE_AUTOGAP_EN
      test_autogap();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
      $finish;
   end

endmodule : tb_morse_symbol_framer
`default_nettype wire
